inst_fetch_queue: RTL and testbench

//  Decoupling queue between PC/I-cache fetch and the dual decoders (decode1/decode2).
//  - Each cycle, accepts one aligned 128-bit fetch line holding 1..4 valid instructions.
//  - Stores each instruction as one entry: inst, pc, predicted-taken flag.
//  - Presents the two oldest entries in program order to the decoders.
//  - Flushed on decode/trap redirect.

---
 rtl/inst_fetch_queue_pkg.sv | 27 ++
 rtl/inst_fetch_queue_if.sv | 42 ++++
 rtl/inst_fetch_queue_unpack.sv | 33 +++
 rtl/inst_fetch_queue.sv | 90 +++++++++
 tb/tb_inst_fetch_queue.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package inst_fetch_queue_pkg;

   localparam int DEPTH      = 8;
   localparam int PTR_W      = 3;
   localparam int CNT_W      = PTR_W + 1;
   localparam int LINE_SLOTS = 4;

   localparam logic [31:0] NOP_INST = 32'h00000013;

   // One queued instruction: word, its own pc and the predictor's taken flag.
   typedef struct packed {
      logic [31:0] inst;
      logic [63:0] pc;
      logic        taken;
   } ifq_entry_t;

   // Value shown on an output port whose entry is not valid.
   function automatic ifq_entry_t nop_entry();
      ifq_entry_t e;
      e.inst  = NOP_INST;
      e.pc    = 64'h0;
      e.taken = 1'b0;
      return e;
   endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch-side and decode-side signals of the fetch queue.
// Handshake: a fetch line is taken on a rising edge where fetch_valid and
// fetch_ready are both high and flush is low; fetch_ready depends only on the
// registered entry count. A decoder consumes an entry on an edge where its
// dec_accept bit and the matching outN_valid are both high (bit1 only counts
// together with bit0).
interface inst_fetch_queue_if;
   import inst_fetch_queue_pkg::*;

   logic             fetch_valid;
   logic             fetch_ready;
   logic [127:0]     fetch_inst;
   logic [63:0]      fetch_pc;
   logic [2:0]       fetch_cnt;
   logic [3:0]       fetch_taken;
   logic             flush;
   logic             out0_valid;
   logic [31:0]      out0_inst;
   logic [63:0]      out0_pc;
   logic             out0_taken;
   logic             out1_valid;
   logic [31:0]      out1_inst;
   logic [63:0]      out1_pc;
   logic             out1_taken;
   logic [1:0]       dec_accept;
   logic [CNT_W-1:0] occupancy;

   // The queue itself.
   modport slave (
      input  fetch_valid, fetch_inst, fetch_pc, fetch_cnt, fetch_taken, flush, dec_accept,
      output fetch_ready, out0_valid, out0_inst, out0_pc, out0_taken,
      output out1_valid, out1_inst, out1_pc, out1_taken, occupancy
   );

   // The fetch unit plus decoders driving the queue.
   modport master (
      output fetch_valid, fetch_inst, fetch_pc, fetch_cnt, fetch_taken, flush, dec_accept,
      input  fetch_ready, out0_valid, out0_inst, out0_pc, out0_taken,
      input  out1_valid, out1_inst, out1_pc, out1_taken, occupancy
   );

endinterface

// File: rtl/inst_fetch_queue_unpack.sv
// Splits an aligned fetch line into up to four entries starting at the
// slot named by pc[3:2], and reports how many of them are real.
module ifq_line_unpack
   import inst_fetch_queue_pkg::*;
(
   input  logic [127:0]         line_i,
   input  logic [63:2]          pc_i,
   input  logic [2:0]           cnt_i,
   input  logic [3:0]           taken_i,
   output ifq_entry_t [3:0]     ent_o,
   output logic [2:0]           n_o
);

   logic [1:0] start_slot;
   logic [2:0] room;
   logic [1:0] slot;

   // Clamp the count to the slots left in the line, then left-align entries.
   always_comb begin
      start_slot = pc_i[3:2];
      room       = 3'd4 - {1'b0, start_slot};
      n_o        = (cnt_i < room) ? cnt_i : room;
      ent_o      = '0;
      slot       = '0;
      for (int j = 0; j < LINE_SLOTS; j++) begin
         slot           = start_slot + 2'(j);
         ent_o[j].inst  = line_i[{slot, 5'b00000} +: 32];
         ent_o[j].pc    = {pc_i[63:4], slot, 2'b00};
         ent_o[j].taken = taken_i[slot];
      end
   end

endmodule

// File: rtl/inst_fetch_queue.sv
// Circular instruction queue between fetch and the two decoders: takes up to
// four instructions per cycle, presents the two oldest, flushes on redirect.
module inst_fetch_queue
   import inst_fetch_queue_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_ni,
   inst_fetch_queue_if.slave   bus
);

   ifq_entry_t       mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   ifq_entry_t [3:0] line_ent;
   logic [2:0]       line_n;
   logic             enq_fire;
   logic [2:0]       enq_n;
   logic             accept0, accept1;
   logic [1:0]       deq_n;
   ifq_entry_t       head, second;

   ifq_line_unpack u_unpack (
      .line_i  (bus.fetch_inst),
      .pc_i    (bus.fetch_pc[63:2]),
      .cnt_i   (bus.fetch_cnt),
      .taken_i (bus.fetch_taken),
      .ent_o   (line_ent),
      .n_o     (line_n)
   );

   // Ready only from the registered count so decode/flush never reach fetch.
   assign bus.fetch_ready = (count_q <= CNT_W'(DEPTH - LINE_SLOTS));
   assign bus.occupancy   = count_q;

   // Work out how many entries enter and leave, and the next pointers/count.
   always_comb begin
      enq_fire = bus.fetch_valid & bus.fetch_ready & ~bus.flush;
      enq_n    = enq_fire ? line_n : 3'd0;
      accept0  = bus.dec_accept[0] & bus.out0_valid;
      accept1  = accept0 & bus.dec_accept[1] & bus.out1_valid;
      deq_n    = {1'b0, accept0} + {1'b0, accept1};
      rd_ptr_d = rd_ptr_q + PTR_W'(deq_n);
      wr_ptr_d = wr_ptr_q + PTR_W'(enq_n);
      count_d  = count_q + CNT_W'(enq_n) - CNT_W'(deq_n);
      if (bus.flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end
   end

   // Pointer and count registers; these are the only state that must reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; ready guarantees four free slots, so writes never hit live data.
   always_ff @(posedge clk_i) begin
      for (int j = 0; j < LINE_SLOTS; j++) begin
         if (enq_fire && (3'(j) < line_n)) begin
            mem_q[wr_ptr_q + PTR_W'(j)] <= line_ent[j];
         end
      end
   end

   // Present the two oldest entries, substituting a nop where invalid.
   always_comb begin
      head           = (count_q >= CNT_W'(1)) ? mem_q[rd_ptr_q] : nop_entry();
      second         = (count_q >= CNT_W'(2)) ? mem_q[rd_ptr_q + PTR_W'(1)] : nop_entry();
      bus.out0_valid = (count_q >= CNT_W'(1));
      bus.out0_inst  = head.inst;
      bus.out0_pc    = head.pc;
      bus.out0_taken = head.taken;
      bus.out1_valid = (count_q >= CNT_W'(2));
      bus.out1_inst  = second.inst;
      bus.out1_pc    = second.pc;
      bus.out1_taken = second.taken;
   end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios with literal expectations,
// then random traffic, all compared each cycle against a queue model.
module tb_inst_fetch_queue;
   import inst_fetch_queue_pkg::*;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   inst_fetch_queue_if bus();

   inst_fetch_queue dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   typedef struct {
      logic [31:0] inst;
      logic [63:0] pc;
      logic        taken;
   } m_ent_t;

   m_ent_t mq[$];
   int     errors = 0;
   int     checks = 0;
   bit     cmp_en = 1'b0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference behaviour applied at each rising edge, from the inputs of that cycle.
   task automatic model_edge();
      bit     ready;
      bit     a0, a1;
      int     s;
      logic [127:0] line;
      m_ent_t e;
      if (!rst_n || bus.flush) begin
         mq.delete();
         return;
      end
      ready = (DEPTH - mq.size()) >= 4;
      a0 = bus.dec_accept[0] && (mq.size() >= 1);
      a1 = a0 && bus.dec_accept[1] && (mq.size() >= 2);
      if (a0) void'(mq.pop_front());
      if (a1) void'(mq.pop_front());
      if (bus.fetch_valid && ready) begin
         s    = int'(bus.fetch_pc[3:2]);
         line = bus.fetch_inst;
         for (int j = 0; j < 4; j++) begin
            if (j < int'(bus.fetch_cnt) && (s + j) < 4) begin
               e.inst  = line[32*(s+j) +: 32];
               e.pc    = {bus.fetch_pc[63:4], 4'((s + j) * 4)};
               e.taken = bus.fetch_taken[s+j];
               mq.push_back(e);
            end
         end
      end
   endtask

   task automatic step(bit fv, logic [63:0] pc, int cnt, logic [127:0] line,
                       logic [3:0] tk, bit fl, logic [1:0] acc);
      bus.fetch_valid = fv;
      bus.fetch_pc    = pc;
      bus.fetch_cnt   = 3'(cnt);
      bus.fetch_inst  = line;
      bus.fetch_taken = tk;
      bus.flush       = fl;
      bus.dec_accept  = acc;
      @(posedge clk);
      #1;
      model_edge();
   endtask

   task automatic idle(logic [1:0] acc);
      step(1'b0, 64'h0, 0, 128'h0, 4'h0, 1'b0, acc);
   endtask

   // Compare the DUT against the model away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("occupancy",   64'(bus.occupancy), 64'(mq.size()));
         chk("fetch_ready", 64'(bus.fetch_ready), 64'((DEPTH - mq.size()) >= 4));
         chk("out0_valid",  64'(bus.out0_valid), 64'(mq.size() >= 1));
         chk("out1_valid",  64'(bus.out1_valid), 64'(mq.size() >= 2));
         chk("out0_inst",   64'(bus.out0_inst), (mq.size() >= 1) ? 64'(mq[0].inst) : 64'(NOP_INST));
         chk("out0_pc",     bus.out0_pc, (mq.size() >= 1) ? mq[0].pc : 64'h0);
         chk("out0_taken",  64'(bus.out0_taken), (mq.size() >= 1) ? 64'(mq[0].taken) : 64'h0);
         chk("out1_inst",   64'(bus.out1_inst), (mq.size() >= 2) ? 64'(mq[1].inst) : 64'(NOP_INST));
         chk("out1_pc",     bus.out1_pc, (mq.size() >= 2) ? mq[1].pc : 64'h0);
         chk("out1_taken",  64'(bus.out1_taken), (mq.size() >= 2) ? 64'(mq[1].taken) : 64'h0);
      end
   end

   localparam logic [31:0] IA = 32'hAAAA0001;
   localparam logic [31:0] IB = 32'hBBBB0002;
   localparam logic [31:0] IC = 32'hCCCC0003;
   localparam logic [31:0] ID = 32'hDDDD0004;

   initial begin
      logic [127:0] rl;
      rst_n = 1'b0;
      bus.fetch_valid = 1'b0;
      bus.fetch_pc    = '0;
      bus.fetch_cnt   = '0;
      bus.fetch_inst  = '0;
      bus.fetch_taken = '0;
      bus.flush       = 1'b0;
      bus.dec_accept  = '0;
      cmp_en = 1'b1;
      idle(2'b00);
      idle(2'b00);
      rst_n = 1'b1;
      chk("rst_occupancy", 64'(bus.occupancy), 64'd0);
      chk("rst_ready",     64'(bus.fetch_ready), 64'd1);
      chk("rst_out0_inst", 64'(bus.out0_inst), 64'h13);

      // Reset in the middle of traffic with five entries held.
      step(1'b1, 64'h80000000, 4, {ID, IC, IB, IA}, 4'h0, 1'b0, 2'b00);
      step(1'b1, 64'h80000010, 1, {ID, IC, IB, IA}, 4'h0, 1'b0, 2'b00);
      chk("t1_pre_occ", 64'(bus.occupancy), 64'd5);
      rst_n = 1'b0;
      mq.delete();
      #1;
      chk("t1_out0_valid", 64'(bus.out0_valid), 64'd0);
      chk("t1_out0_inst",  64'(bus.out0_inst), 64'h13);
      chk("t1_occupancy",  64'(bus.occupancy), 64'd0);
      chk("t1_ready",      64'(bus.fetch_ready), 64'd1);
      idle(2'b00);
      rst_n = 1'b1;

      // Start slot 2, two instructions.
      step(1'b1, 64'h80000008, 2, {ID, IC, IB, IA}, 4'h0, 1'b0, 2'b00);
      chk("t2_out0_inst", 64'(bus.out0_inst), 64'(IC));
      chk("t2_out0_pc",   bus.out0_pc, 64'h80000008);
      chk("t2_out1_inst", 64'(bus.out1_inst), 64'(ID));
      chk("t2_out1_pc",   bus.out1_pc, 64'h8000000C);
      chk("t2_occupancy", 64'(bus.occupancy), 64'd2);
      step(1'b0, 64'h0, 0, 128'h0, 4'h0, 1'b1, 2'b00);

      // Fill to full; the third line must be refused.
      step(1'b1, 64'h80000000, 4, {32'h103, 32'h102, 32'h101, 32'h100}, 4'h0, 1'b0, 2'b00);
      step(1'b1, 64'h80000010, 4, {32'h203, 32'h202, 32'h201, 32'h200}, 4'h0, 1'b0, 2'b00);
      chk("t3_occupancy", 64'(bus.occupancy), 64'd8);
      chk("t3_ready",     64'(bus.fetch_ready), 64'd0);
      step(1'b1, 64'h80000020, 4, {32'h303, 32'h302, 32'h301, 32'h300}, 4'h0, 1'b0, 2'b00);
      chk("t3_full_occ",  64'(bus.occupancy), 64'd8);
      chk("t3_head_pc",   bus.out0_pc, 64'h80000000);
      chk("t3_head_inst", 64'(bus.out0_inst), 64'h100);

      // Dual dequeue with and without a same-cycle line, across the wrap.
      idle(2'b11);
      chk("t4_occ6",  64'(bus.occupancy), 64'd6);
      chk("t4_ready6", 64'(bus.fetch_ready), 64'd0);
      step(1'b1, 64'h80000030, 3, {32'h403, 32'h402, 32'h401, 32'h400}, 4'h0, 1'b0, 2'b11);
      chk("t4_occ4",  64'(bus.occupancy), 64'd4);
      chk("t4_head4", bus.out0_pc, 64'h80000010);
      step(1'b1, 64'h80000030, 3, {32'h403, 32'h402, 32'h401, 32'h400}, 4'h0, 1'b0, 2'b11);
      chk("t4_occ5",  64'(bus.occupancy), 64'd5);
      chk("t4_head5", bus.out0_pc, 64'h80000018);
      idle(2'b11);
      chk("t4_wrap_pc",   bus.out0_pc, 64'h80000030);
      chk("t4_wrap_inst", 64'(bus.out0_inst), 64'h400);
      idle(2'b11);
      chk("t4_occ1",   64'(bus.occupancy), 64'd1);
      chk("t4_out1_v", 64'(bus.out1_valid), 64'd0);

      // Flush beats a same-cycle line and accept.
      step(1'b1, 64'h80000040, 4, {32'h503, 32'h502, 32'h501, 32'h500}, 4'h0, 1'b1, 2'b01);
      chk("t5_occupancy", 64'(bus.occupancy), 64'd0);
      chk("t5_out0_valid", 64'(bus.out0_valid), 64'd0);
      idle(2'b00);
      chk("t5_still_empty", 64'(bus.out0_valid), 64'd0);

      // Taken flag from slot 2; accept bit1 alone consumes nothing.
      step(1'b1, 64'h80000108, 2, {32'h603, 32'h602, 32'h601, 32'h600}, 4'b0100, 1'b0, 2'b00);
      chk("t6_taken0", 64'(bus.out0_taken), 64'd1);
      chk("t6_pc0",    bus.out0_pc, 64'h80000108);
      chk("t6_taken1", 64'(bus.out1_taken), 64'd0);
      idle(2'b10);
      chk("t6_occ", 64'(bus.occupancy), 64'd2);
      step(1'b1, 64'h8000020C, 4, {32'h703, 32'h702, 32'h701, 32'h700}, 4'h0, 1'b0, 2'b00);
      chk("t6_clamp_occ", 64'(bus.occupancy), 64'd3);
      step(1'b0, 64'h0, 0, 128'h0, 4'h0, 1'b1, 2'b00);

      // Random traffic against the model.
      for (int i = 0; i < 800; i++) begin
         rl = {$urandom, $urandom, $urandom, $urandom};
         step(($urandom_range(0, 9) < 7),
              {$urandom, $urandom_range(0, 32'hFFFFFFFF) & 32'hFFFFFFFC},
              $urandom_range(0, 7), rl, 4'($urandom_range(0, 15)),
              ($urandom_range(0, 39) == 0), 2'($urandom_range(0, 3)));
      end
      idle(2'b00);
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
